// File: rtl/weight_fetch_arbiter.sv
// weight_fetch_arbiter
// Shares one external weight-memory read port among NUM_REQ layer engines.
// Requests are granted round-robin, one burst at a time. Each grant issues a
// single command, steers the returned beats to the winner via rd_en, and
// marks the last beat with rd_eop. All outputs are registered.
//
// Optional feature: define WFA_WATCHDOG_EN to build a no-progress watchdog
// that aborts a burst stuck in CMD or DATA for TIMEOUT cycles.
module weight_fetch_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 12,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      mem_cmd_valid,
  input  logic                      mem_cmd_rdy,
  output logic [ADDR_W-1:0]         mem_cmd_addr,
  output logic [LEN_W-1:0]          mem_cmd_len,
  input  logic                      mem_rd_valid,
  output logic [NUM_REQ-1:0]        rd_en,
  output logic [NUM_REQ-1:0]        rd_eop,
  output logic                      busy,
  output logic                      err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  // Reject parameter values the arbiter was never meant to handle.
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("weight_fetch_arbiter: NUM_REQ must be in 2..16");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("weight_fetch_arbiter: TIMEOUT must be at least 1");
  end

  // Index of requester 'off' positions above 'base', wrapping modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base,
                                               input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // One-hot vector with bit 'idx' set.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Registered state and its next-state counterparts.
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic [NUM_REQ-1:0] rd_en_q, rd_en_d;
  logic [NUM_REQ-1:0] rd_eop_q, rd_eop_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  // Round-robin pick: first active request at or above rr.
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [ADDR_W-1:0]  pick_addr;
  logic [LEN_W-1:0]   pick_len;

`ifdef WFA_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            progress;
`endif

  // Search the request vector starting at the round-robin pointer.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && req[rot_idx(rr_q, k)]) begin
        pick_found = 1'b1;
        pick_idx   = rot_idx(rr_q, k);
      end
    end
    pick_addr = req_addr[pick_idx*ADDR_W +: ADDR_W];
    pick_len  = req_len[pick_idx*LEN_W +: LEN_W];
  end

  // Next-state and next-output logic for the burst FSM.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    win_d       = win_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    cmd_valid_d = cmd_valid_q;
    rd_en_d     = '0;
    rd_eop_d    = '0;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          win_d  = pick_idx;
          gnt_d  = onehot(pick_idx);
          addr_d = pick_addr;
          len_d  = pick_len;
          if (pick_len == '0) begin
            // Zero-length burst: no command, just the end-of-burst marker.
            rd_eop_d = onehot(pick_idx);
            state_d  = DONE;
          end else begin
            cmd_valid_d = 1'b1;
            state_d     = CMD;
          end
        end
      end

      CMD: begin
        if (cmd_valid_q && mem_cmd_rdy) begin
          cmd_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = DATA;
        end
      end

      DATA: begin
        if (mem_rd_valid) begin
          rd_en_d = onehot(win_q);
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) begin
            rd_eop_d = onehot(win_q);
            state_d  = DONE;
          end
        end
      end

      DONE: begin
        gnt_d   = '0;
        rr_d    = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // A beat outside DATA has no owner: flag it and drop it.
    if (mem_rd_valid && state_q != DATA) err_d = 1'b1;

`ifdef WFA_WATCHDOG_EN
    // Count cycles without a handshake or a beat; abort on expiry.
    progress = (state_q == CMD  && cmd_valid_q && mem_cmd_rdy) ||
               (state_q == DATA && mem_rd_valid);
    wd_d     = '0;
    if ((state_q == CMD || state_q == DATA) && !progress) begin
      if (wd_q == WD_W'(TIMEOUT - 1)) begin
        err_d       = 1'b1;
        rd_eop_d    = onehot(win_q);
        rd_en_d     = '0;
        cmd_valid_d = 1'b0;
        state_d     = DONE;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      win_q       <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      cmd_valid_q <= 1'b0;
      rd_en_q     <= '0;
      rd_eop_q    <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      win_q       <= win_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      cmd_valid_q <= cmd_valid_d;
      rd_en_q     <= rd_en_d;
      rd_eop_q    <= rd_eop_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

`ifdef WFA_WATCHDOG_EN
  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`endif

  assign gnt           = gnt_q;
  assign mem_cmd_valid = cmd_valid_q;
  assign mem_cmd_addr  = addr_q;
  assign mem_cmd_len   = len_q;
  assign rd_en         = rd_en_q;
  assign rd_eop        = rd_eop_q;
  assign busy          = busy_q;
  assign err           = err_q;

endmodule

// File: tb/tb_weight_fetch_arbiter.sv
// Self-checking bench for weight_fetch_arbiter: a cycle-by-cycle vector table
// followed by hand-written multi-cycle sequences. Define WFA_WATCHDOG_EN to
// also exercise the watchdog abort (TIMEOUT is set to 16 here).
module tb_weight_fetch_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int LEN_W   = 12;
  localparam int TIMEOUT = 16;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]        gnt;
  logic                      mem_cmd_valid;
  logic                      mem_cmd_rdy;
  logic [ADDR_W-1:0]         mem_cmd_addr;
  logic [LEN_W-1:0]          mem_cmd_len;
  logic                      mem_rd_valid;
  logic [NUM_REQ-1:0]        rd_en;
  logic [NUM_REQ-1:0]        rd_eop;
  logic                      busy;
  logic                      err;

  weight_fetch_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
    .req_len(req_len), .gnt(gnt), .mem_cmd_valid(mem_cmd_valid),
    .mem_cmd_rdy(mem_cmd_rdy), .mem_cmd_addr(mem_cmd_addr),
    .mem_cmd_len(mem_cmd_len), .mem_rd_valid(mem_rd_valid), .rd_en(rd_en),
    .rd_eop(rd_eop), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  req;
    logic        rdy;
    logic        rdv;
    logic [3:0]  gnt;
    logic        cv;
    logic [31:0] addr;
    logic [11:0] len;
    logic [3:0]  rd_en;
    logic [3:0]  rd_eop;
    logic        busy;
    logic        err;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_eng(input int i, input logic [31:0] a,
                         input logic [11:0] l);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_len[i*LEN_W +: LEN_W]    = l;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " gnt"},    gnt,           0);
    check({tag, " cv"},     mem_cmd_valid, 0);
    check({tag, " addr"},   mem_cmd_addr,  0);
    check({tag, " len"},    mem_cmd_len,   0);
    check({tag, " rd_en"},  rd_en,         0);
    check({tag, " rd_eop"}, rd_eop,        0);
    check({tag, " busy"},   busy,          0);
    check({tag, " err"},    err,           0);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    req          = '0;
    mem_cmd_rdy  = 1'b0;
    mem_rd_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b0;
    req          = '0;
    req_addr     = '0;
    req_len      = '0;
    mem_cmd_rdy  = 1'b0;
    mem_rd_valid = 1'b0;
    set_eng(0, 32'h100, 12'd4);
    set_eng(1, 32'h200, 12'd3);
    set_eng(2, 32'h300, 12'd0);
    set_eng(3, 32'h400, 12'd1);

    // Vectors: {req, rdy, rdv} applied, then outputs expected after the edge.
    // Single burst to engine 0, len 4.
    vecs[0]  = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 32'h100, 12'd4, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[1]  = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, 32'h100, 12'd4, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[2]  = '{4'b0001, 1'b1, 1'b1, 4'b0001, 1'b0, 32'h100, 12'd4, 4'b0001, 4'b0000, 1'b1, 1'b0};
    vecs[3]  = '{4'b0001, 1'b1, 1'b1, 4'b0001, 1'b0, 32'h100, 12'd4, 4'b0001, 4'b0000, 1'b1, 1'b0};
    vecs[4]  = '{4'b0001, 1'b1, 1'b1, 4'b0001, 1'b0, 32'h100, 12'd4, 4'b0001, 4'b0000, 1'b1, 1'b0};
    vecs[5]  = '{4'b0001, 1'b1, 1'b1, 4'b0001, 1'b0, 32'h100, 12'd4, 4'b0001, 4'b0001, 1'b1, 1'b0};
    vecs[6]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h100, 12'd4, 4'b0000, 4'b0000, 1'b0, 1'b0};
    // Zero-length burst to engine 2 (rr is 1): straight to DONE.
    vecs[7]  = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, 32'h300, 12'd0, 4'b0000, 4'b0100, 1'b1, 1'b0};
    vecs[8]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h300, 12'd0, 4'b0000, 4'b0000, 1'b0, 1'b0};
    // rr is now 3: engine 3 beats engine 0; one cycle of back-pressure.
    vecs[9]  = '{4'b1001, 1'b0, 1'b0, 4'b1000, 1'b1, 32'h400, 12'd1, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[10] = '{4'b1001, 1'b0, 1'b0, 4'b1000, 1'b1, 32'h400, 12'd1, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[11] = '{4'b1001, 1'b1, 1'b0, 4'b1000, 1'b0, 32'h400, 12'd1, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[12] = '{4'b1001, 1'b1, 1'b1, 4'b1000, 1'b0, 32'h400, 12'd1, 4'b1000, 4'b1000, 1'b1, 1'b0};
    vecs[13] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h400, 12'd1, 4'b0000, 4'b0000, 1'b0, 1'b0};
    // Stray beat in IDLE sets the sticky error and produces no rd_en.
    vecs[14] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 32'h400, 12'd1, 4'b0000, 4'b0000, 1'b0, 1'b1};
    vecs[15] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h400, 12'd1, 4'b0000, 4'b0000, 1'b0, 1'b1};
    // rr wrapped to 0; engine 1 wins, then drops req after the grant.
    vecs[16] = '{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 32'h200, 12'd3, 4'b0000, 4'b0000, 1'b1, 1'b1};
    vecs[17] = '{4'b0000, 1'b1, 1'b0, 4'b0010, 1'b0, 32'h200, 12'd3, 4'b0000, 4'b0000, 1'b1, 1'b1};

    // Reset state.
    tick();
    check_zero("reset");
    rst_n = 1'b1;

    for (int v = 0; v < 18; v++) begin
      req          = vecs[v].req;
      mem_cmd_rdy  = vecs[v].rdy;
      mem_rd_valid = vecs[v].rdv;
      tick();
      check($sformatf("v%0d gnt", v),    gnt,           vecs[v].gnt);
      check($sformatf("v%0d cv", v),     mem_cmd_valid, vecs[v].cv);
      check($sformatf("v%0d addr", v),   mem_cmd_addr,  vecs[v].addr);
      check($sformatf("v%0d len", v),    mem_cmd_len,   vecs[v].len);
      check($sformatf("v%0d rd_en", v),  rd_en,         vecs[v].rd_en);
      check($sformatf("v%0d rd_eop", v), rd_eop,        vecs[v].rd_eop);
      check($sformatf("v%0d busy", v),   busy,          vecs[v].busy);
      check($sformatf("v%0d err", v),    err,           vecs[v].err);
    end

    // Round-robin: all four engines request continuously, len 2 each.
    do_reset();
    for (int i = 0; i < 4; i++) set_eng(i, 32'h100 * (i + 1), 12'd2);
    req         = 4'b1111;
    mem_cmd_rdy = 1'b1;
    for (int g = 0; g < 5; g++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (g % 4);
      tick();
      check($sformatf("rr%0d gnt", g),  gnt,           exp_g);
      check($sformatf("rr%0d cv", g),   mem_cmd_valid, 1);
      check($sformatf("rr%0d addr", g), mem_cmd_addr,  32'h100 * ((g % 4) + 1));
      tick();
      check($sformatf("rr%0d cv drop", g), mem_cmd_valid, 0);
      mem_rd_valid = 1'b1;
      for (int b = 0; b < 2; b++) begin
        tick();
        check($sformatf("rr%0d b%0d rd_en", g, b),  rd_en,  exp_g);
        check($sformatf("rr%0d b%0d rd_eop", g, b), rd_eop, (b == 1) ? exp_g : 4'b0000);
      end
      mem_rd_valid = 1'b0;
      tick();
      check($sformatf("rr%0d gnt clr", g), gnt,   0);
      check($sformatf("rr%0d rd_en", g),   rd_en, 0);
      check($sformatf("rr%0d busy", g),    busy,  0);
    end
    req = '0;
    check("rr err", err, 0);

    // Back-pressure: command held 6 cycles, then 3 beats with 1-cycle gaps.
    do_reset();
    set_eng(1, 32'h200, 12'd3);
    req = 4'b0010;
    tick();
    check("bp gnt", gnt, 4'b0010);
    begin
      int n_cv;
      n_cv = 0;
      for (int i = 0; i < 5; i++) begin
        if (mem_cmd_valid) n_cv++;
        check($sformatf("bp addr c%0d", i), mem_cmd_addr, 32'h200);
        check($sformatf("bp len c%0d", i),  mem_cmd_len,  3);
        tick();
      end
      mem_cmd_rdy = 1'b1;
      if (mem_cmd_valid) n_cv++;
      tick();
      mem_cmd_rdy = 1'b0;
      check("bp cv cycles", n_cv, 6);
      check("bp cv drop", mem_cmd_valid, 0);
    end
    for (int b = 0; b < 3; b++) begin
      mem_rd_valid = 1'b1;
      tick();
      mem_rd_valid = 1'b0;
      if (b == 2) req = '0;
      check($sformatf("bp b%0d rd_en", b),  rd_en,  4'b0010);
      check($sformatf("bp b%0d rd_eop", b), rd_eop, (b == 2) ? 4'b0010 : 4'b0000);
      tick();
      check($sformatf("bp gap%0d rd_en", b),  rd_en,  0);
      check($sformatf("bp gap%0d rd_eop", b), rd_eop, 0);
    end
    check("bp busy", busy, 0);
    check("bp err", err, 0);

    // Stray beat, then reset in the middle of DATA.
    mem_rd_valid = 1'b1;
    tick();
    mem_rd_valid = 1'b0;
    check("stray err", err, 1);
    check("stray rd_en", rd_en, 0);
    set_eng(2, 32'h300, 12'd4);
    req         = 4'b0100;
    mem_cmd_rdy = 1'b1;
    tick();
    check("rst gnt pre", gnt, 4'b0100);
    tick();
    mem_rd_valid = 1'b1;
    tick();
    check("rst rd_en pre", rd_en, 4'b0100);
    rst_n = 1'b0;
    tick();
    check_zero("mid-data reset");
    rst_n        = 1'b1;
    mem_rd_valid = 1'b0;
    req          = 4'b0101;
    tick();
    check("post-reset gnt", gnt, 4'b0001);

`ifdef WFA_WATCHDOG_EN
    // Watchdog: len 8 but only 3 beats arrive.
    do_reset();
    set_eng(0, 32'h100, 12'd8);
    req         = 4'b0001;
    mem_cmd_rdy = 1'b1;
    tick();
    tick();
    mem_rd_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      tick();
      check($sformatf("wd b%0d rd_en", b), rd_en, 4'b0001);
    end
    mem_rd_valid = 1'b0;
    req          = '0;
    for (int c = 1; c < 16; c++) begin
      tick();
      check($sformatf("wd c%0d err", c),    err,    0);
      check($sformatf("wd c%0d rd_eop", c), rd_eop, 0);
    end
    tick();
    check("wd abort err",    err,           1);
    check("wd abort rd_eop", rd_eop,        4'b0001);
    check("wd abort rd_en",  rd_en,         0);
    check("wd abort cv",     mem_cmd_valid, 0);
    tick();
    check("wd idle busy", busy, 0);
    check("wd idle gnt",  gnt,  0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_fetch_arbiter.md
Name: weight_fetch_arbiter

Overview:
- Shares one external weight-memory read port among NUM_REQ layer engines, such as conv controllers that each need weight bursts per KG group.
- Accepts burst requests with an address and a length, and grants them round-robin, one burst at a time.
- Issues one command per burst, steers returned beats to the granted engine, and signals end-of-burst.
- Sits between the layer engines' weight loaders and the memory-interface adapter.

Parameters:
- NUM_REQ, 4, number of requesting engines (2..16)
- ADDR_W, 32, memory address width
- LEN_W, 12, burst length field width, in beats
- TIMEOUT, 1024, cycles without a beat before a burst is aborted (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req  in  NUM_REQ  per-engine request; held high until the matching rd_eop
- req_addr  in  NUM_REQ*ADDR_W  per-engine start address; slice i belongs to engine i
- req_len  in  NUM_REQ*LEN_W  per-engine beat count
- gnt  out  NUM_REQ  one-hot grant, registered
- mem_cmd_valid  out  1  command valid
- mem_cmd_rdy  in  1  memory accepts the command
- mem_cmd_addr  out  ADDR_W  latched address of the winner
- mem_cmd_len  out  LEN_W  latched length of the winner
- mem_rd_valid  in  1  read-data beat strobe; data is routed externally using gnt
- rd_en  out  NUM_REQ  per-engine beat strobe, registered
- rd_eop  out  NUM_REQ  per-engine last-beat strobe, coincident with the last rd_en
- busy  out  1  high whenever the state is not IDLE
- err  out  1  sticky error flag, cleared only by reset

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all outputs. State goes to IDLE and the round-robin pointer rr goes to 0. Reset in any state aborts the burst in progress; no rd_eop is issued.
- FSM states: IDLE, CMD, DATA, DONE.
- IDLE:
  - If req is non-zero, the winner is the first requester searched from index rr upward, wrapping modulo NUM_REQ.
  - Next cycle: gnt=onehot(winner), the winner's addr and len are latched, and the state moves to CMD.
  - Zero-length case: if the winner's req_len is 0, state goes to DONE instead, with no command issued and no rd_en.
- CMD:
  - mem_cmd_valid=1 with mem_cmd_addr and mem_cmd_len stable.
  - On the cycle mem_cmd_valid and mem_cmd_rdy are both high, the command completes: mem_cmd_valid drops next cycle, beat counter cnt=0, state moves to DATA.
- DATA:
  - Each cycle with mem_rd_valid=1 gives rd_en[winner]=1 one cycle later and increments cnt.
  - When the beat with cnt==len-1 arrives, rd_eop[winner] pulses in the same cycle as that rd_en, and the state moves to DONE.
- DONE (1 cycle):
  - gnt clears, rr = winner+1 modulo NUM_REQ, state returns to IDLE.
  - For a zero-length burst, rd_eop[winner] pulses alone in this cycle with rd_en=0.
  - Minimum gap between bursts is 1 idle cycle, so a new grant appears at the earliest 2 cycles after rd_eop.
- Arbitration and request rules:
  - Arbitration happens only in IDLE.
  - A req that drops before it is granted is forgotten.
  - req, req_addr and req_len changes from the granted engine after the grant are ignored, because the values are latched.
- Stray beats: mem_rd_valid in IDLE, CMD or DONE sets err; the beat is dropped and produces no rd_en.
- Width rules:
  - cnt is LEN_W bits wide.
  - len is interpreted unsigned, with a maximum burst of 2^LEN_W-1.
  - The address is passed through unmodified.
- Pointer wrap: rr wraps from NUM_REQ-1 to 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: WFA_WATCHDOG_EN.
- When defined:
  - A counter counts cycles in CMD or DATA with no progress, where progress means a command handshake or a beat.
  - When the counter reaches TIMEOUT, the arbiter sets err and pulses rd_eop[winner] with rd_en=0 (abort).
  - mem_cmd_valid drops, and the state moves to DONE.
  - Beats arriving later are treated as stray.
- When not defined:
  - No counter is built, CMD and DATA wait indefinitely, and TIMEOUT is unused.

Test Plan:
- Single burst: req=0001, addr=0x100, len=4, mem_cmd_rdy=1, 4 consecutive beats -> gnt=0001 one cycle after req; one command with addr 0x100, len 4; rd_en[0] high for 4 cycles with rd_eop[0] on the 4th; gnt=0 after DONE; busy low afterwards.
- Round-robin: req=1111 held, every len=2 -> grant order 0,1,2,3,0; each engine receives exactly 2 rd_en and 1 rd_eop per grant.
- Back-pressure and gapped beats: mem_cmd_rdy low for 5 cycles, then beats with 1-cycle gaps, len=3 -> mem_cmd_valid held for 6 cycles with addr and len stable; exactly 3 rd_en; rd_eop on the third.
- Zero length: req=0100, len=0 -> gnt=0100, no mem_cmd_valid, rd_eop[2] pulses with rd_en=0, rr becomes 3.
- Stray beat and reset: mem_rd_valid in IDLE -> err=1 and no rd_en. Then rst_n low mid-DATA -> all outputs 0 the next cycle, err cleared, next grant goes to engine 0.
- Watchdog (WFA_WATCHDOG_EN, TIMEOUT=16): len=8, only 3 beats delivered -> 16 idle cycles after the third beat, err=1 and rd_eop[winner] pulses with rd_en=0, then the arbiter returns to IDLE.
